// File: rtl/sid_regbus.sv
// sid_regbus: multi-chip SID bus decode, write-only register banks, read-back mux, data-bus retention/fade.
// Latency: data_o and wr_pulse are registered, 1 clk after the sampled bus cycle; writes commit on phi2.
// Backpressure: none, every bus cycle is accepted. Option macro SID_BUS_BITFADE_EN selects per-bit fade.
module sid_regbus #(
    parameter int NUM_CHIPS = 2,
    parameter int TTL_W     = 10,
    parameter int TTL_6581  = 7,
    parameter int TTL_8580  = 664
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     tick_ms,
    input  logic                     phi2,
    input  logic [NUM_CHIPS-1:0]     cs,
    input  logic                     oe,
    input  logic                     we,
    input  logic [4:0]               addr,
    input  logic [7:0]               data_i,
    input  logic [NUM_CHIPS-1:0]     model,
    input  logic [NUM_CHIPS*32-1:0]  ro_regs,
    output logic [7:0]               data_o,
    output logic [NUM_CHIPS*200-1:0] wo_regs,
    output logic [NUM_CHIPS-1:0]     wr_pulse
);

    localparam int SEL_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
`ifdef SID_BUS_BITFADE_EN
    // Age must reach the last bit's threshold, which can exceed TTL_W bits.
    localparam int TTL_MAX = (TTL_8580 > TTL_6581) ? TTL_8580 : TTL_6581;
    localparam int SAT_MAX = TTL_MAX + 7 * (TTL_MAX / 8);
    localparam int SAT_W   = $clog2(SAT_MAX + 1);
    localparam int AGE_W   = (SAT_W > TTL_W) ? SAT_W : TTL_W;
`else
    localparam int AGE_W   = TTL_W;
`endif
    localparam logic [AGE_W-1:0] TTL_A = AGE_W'(TTL_6581);
    localparam logic [AGE_W-1:0] TTL_B = AGE_W'(TTL_8580);

    logic [7:0]               data_q, data_d;
    logic [NUM_CHIPS*200-1:0] wo_q, wo_d;
    logic [NUM_CHIPS-1:0]     pulse_q, pulse_d;
    logic [7:0]               bus_q [NUM_CHIPS];
    logic [7:0]               bus_d [NUM_CHIPS];
    logic [AGE_W-1:0]         age_q [NUM_CHIPS];
    logic [AGE_W-1:0]         age_d [NUM_CHIPS];

    logic [SEL_W-1:0]         sel;
    logic                     any_cs;
    logic                     rd;
    logic [1:0]               ro_idx;

    // Bus decode: lowest selected chip wins the read path; a write cycle suppresses reads.
    always_comb begin
        sel = '0;
        for (int c = NUM_CHIPS - 1; c >= 0; c--) begin
            if (cs[c]) sel = SEL_W'(c);
        end
        any_cs = |cs;
        rd     = any_cs & oe & ~we & (addr >= 5'h19) & (addr <= 5'h1C);
        ro_idx = 2'(addr - 5'h19);
    end

    // Read mux: read-only register, else the retained bus value of the selected chip.
    always_comb begin
        data_d = 8'h00;
        if (rd) begin
            data_d = ro_regs[int'(sel) * 32 + int'(ro_idx) * 8 +: 8];
        end else if (any_cs) begin
            data_d = bus_q[sel];
        end
    end

    // Register writes and per-chip bus retention, all committed on phi2.
    always_comb begin
        logic [AGE_W-1:0] ttl;
`ifdef SID_BUS_BITFADE_EN
        logic [AGE_W-1:0] step;
        logic [AGE_W-1:0] sat;
        step = '0;
        sat  = '0;
`endif
        ttl     = '0;
        wo_d    = wo_q;
        pulse_d = '0;
        for (int c = 0; c < NUM_CHIPS; c++) begin
            bus_d[c] = bus_q[c];
            age_d[c] = age_q[c];
            ttl      = model[c] ? TTL_B : TTL_A;
            if (phi2) begin
                if (cs[c] & we) begin
                    bus_d[c] = data_i;
                    age_d[c] = '0;
                    if (addr < 5'h19) begin
                        wo_d[c * 200 + int'(addr) * 8 +: 8] = data_i;
                        pulse_d[c] = 1'b1;
                    end
                end else if (cs[c] & rd) begin
                    // A read drives the bus with the value presented last clk.
                    bus_d[c] = data_q;
                    age_d[c] = '0;
                end else begin
`ifdef SID_BUS_BITFADE_EN
                    step = ttl >> 3;
                    sat  = ttl + AGE_W'(7) * step;
                    for (int i = 0; i < 8; i++) begin
                        if (age_q[c] >= ttl + AGE_W'(i) * step) bus_d[c][i] = 1'b0;
                    end
                    age_d[c] = (age_q[c] >= sat) ? sat : age_q[c] + AGE_W'(tick_ms);
`else
                    // >= so a switch to a shorter TTL clears at once; age is clamped to ttl.
                    if (age_q[c] >= ttl) begin
                        bus_d[c] = 8'h00;
                        age_d[c] = ttl;
                    end else begin
                        age_d[c] = age_q[c] + AGE_W'(tick_ms);
                    end
`endif
                end
            end
        end
    end

    // State registers; async reset drops any write in flight.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            data_q  <= '0;
            wo_q    <= '0;
            pulse_q <= '0;
            for (int c = 0; c < NUM_CHIPS; c++) begin
                bus_q[c] <= '0;
                age_q[c] <= '0;
            end
        end else begin
            data_q  <= data_d;
            wo_q    <= wo_d;
            pulse_q <= pulse_d;
            for (int c = 0; c < NUM_CHIPS; c++) begin
                bus_q[c] <= bus_d[c];
                age_q[c] <= age_d[c];
            end
        end
    end

    assign data_o   = data_q;
    assign wo_regs  = wo_q;
    assign wr_pulse = pulse_q;

endmodule
